// File: rtl/sar_conversion_ctrl.sv
// sar_conversion_ctrl: successive-approximation ADC conversion controller.
// Walks the R2R DAC trial code from MSB to LSB. For each bit it holds the trial
// code for a settle period, samples the comparator, then keeps or clears that bit.
// Optional macro SAR_COMP_SYNC_EN adds a 2-flop synchronizer on comp_in and
// stretches each settle period by two cycles to cover the synchronizer delay.
module sar_conversion_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

`ifdef SAR_COMP_SYNC_EN
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES + 2;
`else
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES;
`endif
    localparam int unsigned CNT_W = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             comp;
    logic [WIDTH-1:0] kept_code_c;
    logic [WIDTH-1:0] next_trial_c;

`ifdef SAR_COMP_SYNC_EN
    logic [1:0] comp_sync;

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comp_sync <= 2'b00;
        end else begin
            comp_sync <= {comp_sync[0], comp_in};
        end
    end

    assign comp = comp_sync[1];
`else
    assign comp = comp_in;
`endif

    // Keep/clear the bit under test, then raise the next lower trial bit
    always_comb begin
        kept_code_c = dac_code;
        if (!comp) begin
            kept_code_c[idx] = 1'b0;
        end
        next_trial_c = kept_code_c | ((WIDTH'(1) << idx) >> 1);
    end

    // Conversion sequencer with registered handshake and DAC outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            dac_code <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= IDX_W'(WIDTH - 1);
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
                        idx      <= IDX_W'(WIDTH - 1);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    busy <= 1'b1;
                    if (cnt == CNT_W'(SETTLE_LEN - 1)) begin
                        cnt   <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (idx == '0) begin
                        dac_code <= kept_code_c;
                        result   <= kept_code_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        dac_code <= next_trial_c;
                        idx      <= idx - IDX_W'(1);
                        busy     <= 1'b1;
                        state    <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sar_conversion_ctrl.md
Name: sar_conversion_ctrl

Overview:
- Successive-approximation conversion controller for the ADC.
- Sequences the R2R DAC trial code MSB to LSB.
- Waits a programmable settle time per bit, samples the comparator, then keeps or clears each trial bit.
- Handshakes with the system through start/busy/done and holds the final code on `result`.

Parameters:
- WIDTH, 8, number of DAC/result bits (>= 2).
- SETTLE_CYCLES, 2, cycles the DAC output is held before each comparator sample (>= 1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  conversion request; sampled only in IDLE.
- comp_in  input  1  comparator output; 1 = Vin >= DAC voltage.
- dac_code  output  WIDTH  trial code driving the R2R ladder.
- busy  output  1  high while a conversion is in progress (SETTLE/DECIDE).
- done  output  1  single-cycle pulse when `result` has been updated.
- result  output  WIDTH  last completed conversion code; held until the next done.

Behaviour:
- Reset (async, any state): state=IDLE, dac_code=0, result=0, busy=0, done=0, bit index=WIDTH-1, settle counter=0.
- States (one-hot or binary, implementer's choice): IDLE, SETTLE, DECIDE, DONE.
- IDLE:
  - busy=0, done=0, dac_code holds its last value.
  - On an edge with start=1: dac_code <= 1<<(WIDTH-1), idx <= WIDTH-1, cnt <= 0, go to SETTLE.
- SETTLE:
  - busy=1; cnt increments each edge.
  - When cnt==SETTLE_CYCLES-1, go to DECIDE and clear cnt.
  - SETTLE occupies exactly SETTLE_CYCLES cycles.
- DECIDE (1 cycle, busy=1), comp_in sampled on the edge:
  - comp_in=0: clear dac_code[idx].
  - comp_in=1: keep dac_code[idx].
  - idx>0: idx <= idx-1, set dac_code[idx-1]=1 (same edge, after the keep/clear), go to SETTLE.
  - idx==0: result <= final code (including the bit-0 decision), go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, dac_code holds the final code; next edge goes to IDLE.
  - start is ignored in DONE.
- Latency:
  - Start-sample edge to DONE entry = WIDTH*(SETTLE_CYCLES+1) cycles.
  - Minimum start-to-start spacing = that value + 2 cycles.
- start asserted while busy or in DONE: ignored, no queueing.
- start held high continuously: conversions repeat back-to-back with one IDLE cycle between them.
- comp_in is only used in DECIDE; its value in other states has no effect.
- Reset mid-conversion: abort immediately; the old result is lost (result=0); no done pulse.
- The bit index never wraps; only the idx==0 DECIDE exits the bit loop.

Optional Feature:
- Macro SAR_COMP_SYNC_EN.
- Defined:
  - comp_in passes through a 2-flop synchronizer (reset to 0) before use.
  - SETTLE lasts SETTLE_CYCLES+2 cycles, so each sample reflects the current trial code.
  - Latency = WIDTH*(SETTLE_CYCLES+3).
- Undefined:
  - comp_in is used directly with no synchronizer.
  - Latency as in Behaviour.

Test Plan (WIDTH=8, SETTLE_CYCLES=2; the bench models comp_in = (vin >= dac_code) combinationally):
1. vin=0xA5, 1-cycle start pulse:
   - busy rises the cycle after the start edge.
   - DONE is entered 24 edges after the start edge; done is high for exactly 1 cycle.
   - result=0xA5; the dac_code trial sequence begins 0x80, 0xC0, 0xA0, 0xB0, 0xA8.
2. vin=0x00 → result=0x00. vin=0xFF → result=0xFF. Each has exactly one done pulse.
3. start re-pulsed at cycles 5 and 20 of a conversion with vin=0x3C:
   - Both pulses are ignored; a single conversion completes with result=0x3C.
4. reset asserted mid-edge-cycle at cycle 10 of a conversion:
   - busy, done, dac_code and result go to 0 immediately (asynchronously), with no done pulse.
   - A new start after reset release converts vin=0x5A to 0x5A.
5. start held high, vin switched from 0x11 to 0xEE during the first conversion:
   - Results are 0x11 then 0xEE; done pulses are 26 cycles apart.
6. With SAR_COMP_SYNC_EN defined, vin=0xA5:
   - result=0xA5; DONE is entered 40 edges after the start edge.
